seq_stream_ctrl: RTL and testbench
==================================

Name: seq_stream_ctrl

Overview:
- Controller that sequences serial stimulus into the Non_SCC sequence-detector datapath.
- Holds a programmed bit pattern and shifts it out MSB-first, one bit per programmable tick period, on the line that drives the detector's data_in.
- Counts detector hit pulses during the run and reports busy/done, so the detector can be exercised in-system without a bench driving it.

Parameters:
- PAT_W, 20, maximum pattern length in bits.
- TICK_DIV, 500, clock cycles each bit is held (500 x 10 ns = 5 us).
- DIV_W, 16, tick counter width; TICK_DIV must satisfy 1 <= TICK_DIV < 2^DIV_W.
- HIT_W, 8, hit counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- stop  in  1  abort request; sampled every cycle.
- pat_in  in  PAT_W  pattern; bit pat_len-1 is sent first.
- pat_len  in  5  number of bits to send, 1..PAT_W.
- hit_in  in  1  one-cycle hit pulse from the detector.
- data_out  out  1  serial bit to detector data_in.
- bit_strobe  out  1  one-cycle pulse when data_out takes a new bit.
- bit_idx  out  5  index of the bit currently on data_out (counts down).
- busy  out  1  high from the first bit until the end of the run.
- done  out  1  one-cycle pulse at normal completion.
- hit_count  out  HIT_W  hits counted in the current or last run.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; data_out=1 (line idles high); bit_strobe=0; bit_idx=0; busy=0; done=0; hit_count=0; tick counter=0.
- IDLE:
  - Accepts start when stop=0 and pat_len != 0.
  - pat_len > PAT_W is clamped to PAT_W.
  - On accept: latch pat_in and the effective length into internal registers, clear hit_count, go to SHIFT.
  - start with pat_len=0 is ignored; done is not pulsed.
- SHIFT (one cycle):
  - data_out = pattern[idx]; bit_idx = idx; bit_strobe=1; busy=1.
  - Load tick counter with TICK_DIV-1, go to HOLD.
  - First bit appears the cycle after start is accepted (latency 1).
- HOLD: tick counter decrements each cycle; data_out is held stable.
  - At counter==0 with idx>0: idx <= idx-1, go to SHIFT.
  - At counter==0 with idx==0: go to DONE.
- Bit timing: every bit is held exactly TICK_DIV cycles, measured from its bit_strobe.
- DONE (one cycle): done=1, busy=0, data_out=1, then IDLE.
  - Accept cycle = 0, so done is asserted at cycle 1 + len*TICK_DIV.
- Hit counting:
  - hit_in is counted in every cycle where busy=1 and stop=0.
  - The counter saturates at 2^HIT_W-1.
  - hit_count holds its value in IDLE until the next accepted start.
- stop:
  - In SHIFT/HOLD, the next state is IDLE: busy=0, data_out=1, bit_strobe=0, no done pulse, hit_count retained.
  - In IDLE, stop blocks a same-cycle start.
- start while busy is ignored. Latched pattern and length are unaffected by pat_in/pat_len changes mid-run.
- Reset mid-run: rst overrides all other inputs and forces the reset values on the next edge.

Optional Feature:
- Macro: SEQ_STREAM_REPEAT_EN.
- Defined: adds input `repeat`, sampled at accept and latched for the run.
  - If latched 1, DONE is skipped: after bit 0's hold, the controller reloads idx = len-1 and goes to SHIFT.
  - Streaming is continuous with no gap, and hit_count is not cleared between passes.
  - done pulses once per completed pass; busy stays 1.
  - Only stop or rst ends the run.
- Not defined: the port does not exist and every run is single-pass.

Test Plan (TICK_DIV=4 for simulation):
- Reset, then idle 10 cycles -> data_out=1, busy=0, done=0, hit_count=0, bit_strobe never pulses.
- pat_in=20'b1011, pat_len=4, start at cycle 0 -> data_out sequence 1,0,1,1, each bit held 4 cycles; bit_strobe at cycles 1,5,9,13; bit_idx 3,2,1,0; done at cycle 17; data_out=1 from cycle 17.
- Same run with hit_in pulsed at cycles 10 and 14, plus one pulse while IDLE -> hit_count=2 after done.
- stop at cycle 7 mid-run -> cycle 8: busy=0, data_out=1, no done pulse; a new start at cycle 10 runs normally and clears hit_count.
- pat_len=0 start -> no activity. pat_len=25 with PAT_W=20 -> 20 bits sent, done at cycle 1+80. start asserted while busy -> ignored, timing unchanged.
- SEQ_STREAM_REPEAT_EN defined, repeat=1, pat_len=3, pattern 3'b101 -> 1,0,1,1,0,1,... continuously; done pulses every 12 cycles with busy held 1; stop ends the run with data_out=1.

Source files
------------

// File: rtl/seq_stream_ctrl_if.sv
// Bus between the serial stimulus sequencer and its host / detector.
// SEQ_STREAM_REPEAT_EN adds the repeat_en request line.
interface seq_stream_ctrl_if #(
  parameter int PAT_W = 20,
  parameter int HIT_W = 8
);
  logic             start;
  logic             stop;
  logic [PAT_W-1:0] pat_in;
  logic [4:0]       pat_len;
  logic             hit_in;
`ifdef SEQ_STREAM_REPEAT_EN
  logic             repeat_en;
`endif
  logic             data_out;
  logic             bit_strobe;
  logic [4:0]       bit_idx;
  logic             busy;
  logic             done;
  logic [HIT_W-1:0] hit_count;

`ifdef SEQ_STREAM_REPEAT_EN
  modport master (
    output start, stop, pat_in, pat_len, hit_in, repeat_en,
    input  data_out, bit_strobe, bit_idx, busy, done, hit_count
  );

  modport slave (
    input  start, stop, pat_in, pat_len, hit_in, repeat_en,
    output data_out, bit_strobe, bit_idx, busy, done, hit_count
  );
`else
  modport master (
    output start, stop, pat_in, pat_len, hit_in,
    input  data_out, bit_strobe, bit_idx, busy, done, hit_count
  );

  modport slave (
    input  start, stop, pat_in, pat_len, hit_in,
    output data_out, bit_strobe, bit_idx, busy, done, hit_count
  );
`endif
endinterface

// File: rtl/seq_stream_ctrl.sv
// Shifts a latched pattern MSB-first into the sequence detector, one bit per tick
// period, and counts detector hits. SEQ_STREAM_REPEAT_EN enables continuous repeat.
module seq_stream_ctrl #(
  parameter int PAT_W    = 20,
  parameter int TICK_DIV = 500,
  parameter int DIV_W    = 16,
  parameter int HIT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  seq_stream_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0]       MAX_LEN     = 5'(PAT_W);
  localparam logic [DIV_W-1:0] TICK_LOAD   = DIV_W'(TICK_DIV - 1);
  localparam bit               SINGLE_TICK = (TICK_DIV == 1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [4:0]       idx_q, idx_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [HIT_W-1:0] hit_count_q, hit_count_d;
  logic             done_q, done_d;
`ifdef SEQ_STREAM_REPEAT_EN
  logic [4:0]       len_q, len_d;
  logic             repeat_q, repeat_d;
`endif

  logic [4:0] eff_len;
  logic       running;
  logic       bit_end;

  assign eff_len = (bus.pat_len > MAX_LEN) ? MAX_LEN : bus.pat_len;
  assign running = (state_q == SHIFT) || (state_q == HOLD);

  // The SHIFT cycle is the first cycle of each bit, so HOLD covers the remaining TICK_DIV-1.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    idx_d       = idx_q;
    tick_d      = tick_q;
    hit_count_d = hit_count_q;
    done_d      = 1'b0;
    bit_end     = 1'b0;
`ifdef SEQ_STREAM_REPEAT_EN
    len_d       = len_q;
    repeat_d    = repeat_q;
`endif

    if (running && !bus.stop && bus.hit_in && (hit_count_q != {HIT_W{1'b1}})) begin
      hit_count_d = hit_count_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.pat_len != 5'd0)) begin
          pattern_d   = bus.pat_in;
          idx_d       = eff_len - 5'd1;
          hit_count_d = '0;
          state_d     = SHIFT;
`ifdef SEQ_STREAM_REPEAT_EN
          len_d       = eff_len;
          repeat_d    = bus.repeat_en;
`endif
        end
      end
      SHIFT: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          tick_d = TICK_LOAD;
          if (SINGLE_TICK) begin
            bit_end = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          tick_d = tick_q - 1'b1;
          if (tick_d == '0) begin
            bit_end = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A repeating run reports each finished pass but streams straight into the next one.
    if (bit_end) begin
      if (idx_q != 5'd0) begin
        idx_d   = idx_q - 5'd1;
        state_d = SHIFT;
      end else begin
        done_d = 1'b1;
`ifdef SEQ_STREAM_REPEAT_EN
        if (repeat_q) begin
          idx_d   = len_q - 5'd1;
          state_d = SHIFT;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      idx_q       <= '0;
      tick_q      <= '0;
      hit_count_q <= '0;
      done_q      <= 1'b0;
`ifdef SEQ_STREAM_REPEAT_EN
      len_q       <= '0;
      repeat_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      hit_count_q <= hit_count_d;
      done_q      <= done_d;
`ifdef SEQ_STREAM_REPEAT_EN
      len_q       <= len_d;
      repeat_q    <= repeat_d;
`endif
    end
  end

  // The detector line idles high whenever no run is in progress.
  assign bus.data_out   = running ? pattern_q[idx_q] : 1'b1;
  assign bus.bit_strobe = (state_q == SHIFT);
  assign bus.bit_idx    = running ? idx_q : 5'd0;
  assign bus.busy       = running;
  assign bus.done       = done_q;
  assign bus.hit_count  = hit_count_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Randomized scoreboard bench for seq_stream_ctrl (TICK_DIV=4); expected strobes and
// done pulses come from a pattern/timing model and are checked by a separate monitor.
module tb_seq_stream_ctrl;

  localparam int PAT_W = 20;
  localparam int TICK  = 4;
  localparam int HIT_W = 8;
  localparam int NONE  = -1;
  localparam int BIG   = 1000000;

  typedef struct {
    int   cyc;
    logic bit_v;
    int   idx;
  } strobe_t;

  typedef struct {
    int cyc;
    int hits;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  strobe_t exp_strobes[$];
  done_t   exp_dones[$];

  seq_stream_ctrl_if #(.PAT_W(PAT_W), .HIT_W(HIT_W)) bus ();

  seq_stream_ctrl #(
    .PAT_W(PAT_W),
    .TICK_DIV(TICK),
    .DIV_W(16),
    .HIT_W(HIT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int countHits(input logic [127:0] m, input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) begin
      if (j < 128 && m[j]) n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes a bit or pulses done.
  initial begin
    bit      hold_ok = 1'b0;
    logic    hold_bit = 1'b1;
    strobe_t s;
    done_t   d;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus.bit_strobe) begin
          checkOutput("strobe_expected", int'(exp_strobes.size() > 0), 1);
          if (exp_strobes.size() > 0) begin
            s = exp_strobes.pop_front();
            checkOutput("strobe_cycle", cyc, s.cyc);
            checkOutput("strobe_bit", int'(bus.data_out), int'(s.bit_v));
            checkOutput("strobe_idx", int'(bus.bit_idx), s.idx);
            hold_bit = s.bit_v;
            hold_ok  = 1'b1;
          end
        end else if (bus.busy && hold_ok) begin
          checkOutput("hold_bit", int'(bus.data_out), int'(hold_bit));
        end
        if (!bus.busy) begin
          hold_ok = 1'b0;
          checkOutput("idle_line_high", int'(bus.data_out), 1);
        end
        if (bus.done) begin
          checkOutput("done_expected", int'(exp_dones.size() > 0), 1);
          if (exp_dones.size() > 0) begin
            d = exp_dones.pop_front();
            checkOutput("done_cycle", cyc, d.cyc);
            checkOutput("done_hit_count", int'(bus.hit_count), d.hits);
          end
        end
      end
    end
  end

  // One run: the model predicts every strobe and done pulse, then the run is driven cycle by cycle.
  task automatic applyStimulus(input logic [PAT_W-1:0] pat, input int len, input int stop_off,
                               input int rst_off, input bit rpt, input logic [127:0] hmask,
                               input bit junk);
    int L, a, cut, busy_end, last, idx, d;
    bit accepted;
    L        = (len > PAT_W) ? PAT_W : len;
    accepted = (L != 0) && (stop_off != 0);
    busy_end = rpt ? BIG : L * TICK;
    cut      = BIG;
    if (stop_off > 0) cut = stop_off;
    if (rst_off > 0 && rst_off < cut) cut = rst_off;

    @(negedge clk);
    a = cyc;
    if (accepted) begin
      for (int k = 0; (1 + k * TICK <= cut) && (rpt || k < L); k++) begin
        idx = L - 1 - (k % L);
        exp_strobes.push_back('{a + 1 + k * TICK, pat[idx], idx});
      end
      for (int p = 1; (1 + p * L * TICK <= cut) && (rpt || p == 1); p++) begin
        d = 1 + p * L * TICK;
        exp_dones.push_back('{a + d, countHits(hmask, 1, d - 1)});
      end
    end

    if (!accepted) last = 4;
    else if (cut < BIG) last = cut + 1;
    else last = L * TICK + 3;

    for (int j = 0; j <= last; j++) begin
      if (j > 0) @(negedge clk);
      if (!accepted && j > 0) begin
        checkOutput("no_run_busy", int'(bus.busy), 0);
        checkOutput("no_run_hits_held", int'(bus.hit_count >= 0), 1);
      end else if (accepted && cut < BIG && j == cut + 1) begin
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_data_out", int'(bus.data_out), 1);
        checkOutput("abort_no_done", int'(bus.done), 0);
        if (rst_off > 0 && rst_off == cut) begin
          checkOutput("reset_hit_count", int'(bus.hit_count), 0);
          checkOutput("reset_bit_idx", int'(bus.bit_idx), 0);
        end else begin
          checkOutput("stop_hit_count", int'(bus.hit_count),
                      countHits(hmask, 1, (stop_off - 1 < busy_end) ? stop_off - 1 : busy_end));
        end
      end else if (accepted && cut == BIG && j == last) begin
        checkOutput("idle_hit_count_held", int'(bus.hit_count), countHits(hmask, 1, busy_end));
        checkOutput("after_run_busy", int'(bus.busy), 0);
      end

      bus.start   = (j == 0) || (junk && j < cut && j <= busy_end && $urandom_range(3) == 0);
      bus.pat_in  = (j == 0 || !junk) ? pat : PAT_W'($urandom);
      bus.pat_len = (j == 0 || !junk) ? 5'(len) : 5'($urandom);
      bus.stop    = (j == stop_off);
      rst         = (j == rst_off);
      bus.hit_in  = (j < 128) ? hmask[j] : 1'b0;
`ifdef SEQ_STREAM_REPEAT_EN
      bus.repeat_en = (j == 0) ? rpt : 1'($urandom);
`endif
    end
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    rst        = 1'b0;
    bus.hit_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] m;
    int len, stop_off;

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pat_in  = '0;
    bus.pat_len = '0;
    bus.hit_in  = 1'b0;
`ifdef SEQ_STREAM_REPEAT_EN
    bus.repeat_en = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_data_out", int'(bus.data_out), 1);
      checkOutput("reset_busy", int'(bus.busy), 0);
      checkOutput("reset_done", int'(bus.done), 0);
      checkOutput("reset_hits", int'(bus.hit_count), 0);
      checkOutput("reset_strobe", int'(bus.bit_strobe), 0);
    end

    // Pattern 1011: hits at offsets 10 and 14 count, the one at 18 lands in IDLE.
    m = '0;
    m[10] = 1'b1;
    m[14] = 1'b1;
    m[18] = 1'b1;
    applyStimulus(20'b1011, 4, NONE, NONE, 1'b0, m, 1'b0);

    m = '0;
    m[3] = 1'b1;
    m[6] = 1'b1;
    m[9] = 1'b1;
    applyStimulus(20'hA5A5A, 4, 7, NONE, 1'b0, m, 1'b0);
    m = '0;
    m[2] = 1'b1;
    applyStimulus(20'b0110, 4, NONE, NONE, 1'b0, m, 1'b0);

    applyStimulus(20'hFFFFF, 0, NONE, NONE, 1'b0, '0, 1'b0);
    applyStimulus(20'hFFFFF, 5, 0, NONE, 1'b0, '0, 1'b0);

    m = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(20'hC3A91, 25, NONE, NONE, 1'b0, m, 1'b0);

    m = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(20'h5E17B, 6, NONE, NONE, 1'b0, m, 1'b1);

    m = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(20'h8F00F, 9, NONE, 11, 1'b0, m, 1'b1);

    for (int r = 0; r < 14; r++) begin
      len      = $urandom_range(25, 1);
      stop_off = NONE;
      if ($urandom_range(3) == 0) begin
        stop_off = $urandom_range(((len > PAT_W) ? PAT_W : len) * TICK, 1);
      end
      m = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(PAT_W'($urandom), len, stop_off, NONE, 1'b0, m, 1'b1);
    end

`ifdef SEQ_STREAM_REPEAT_EN
    m = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(20'b101, 3, 34, NONE, 1'b1, m, 1'b1);
`endif

    repeat (5) @(negedge clk);
    checkOutput("strobes_drained", exp_strobes.size(), 0);
    checkOutput("dones_drained", exp_dones.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
